// File: rtl/mmp_iddmm_drv.sv
// mmp_iddmm_drv: loads x/y/m operands into the IDDMM multiplier, kicks it, buffers the
// returned result words and replays them to the host on a valid/ready stream.
module mmp_iddmm_drv #(
  parameter int K       = 128,
  parameter int N       = 16,
  parameter int ADDR_W  = $clog2(N),
  parameter int TIMEOUT = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_keep_m,
  input  logic [K-1:0]      cmd_m1,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [K-1:0]      op_x,
  input  logic [K-1:0]      op_y,
  input  logic [K-1:0]      op_m,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_end,
  input  logic              task_grant,
  input  logic [K-1:0]      task_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);
  localparam int CW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, DRAIN} state_t;
  state_t state, state_n;
  logic keep_m;
  logic [K-1:0] m1;
  logic [CW-1:0] wcnt, rcnt, rcnt_f, idx, idx_n;
  logic [TW-1:0] tcnt;
  logic [K-1:0] bufm [N];
  logic cmd_hs, op_hs, res_hs, grant_ok, drop, timeout;
  logic [2:0] ena_d;
  logic req_d, done_d, rv_d, rl_d;
  logic [K-1:0] rd_d;
  logic [1:0] err_d;
  assign cmd_hs   = cmd_valid & cmd_ready;
  assign op_hs    = op_valid & op_ready;
  assign res_hs   = res_valid & res_ready;
  assign grant_ok = state == WAIT && task_grant && rcnt < CW'(N);
  assign drop     = state == WAIT && task_grant && rcnt >= CW'(N);
  assign rcnt_f   = rcnt + CW'(grant_ok);
  assign timeout  = state == WAIT && tcnt == TW'(TIMEOUT - 1);
  assign idx_n    = idx + CW'(res_hs);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_hs ? LOAD : IDLE;
      LOAD:    state_n = (op_hs && wcnt == CW'(N - 1)) ? KICK : LOAD;
      KICK:    state_n = WAIT;
      WAIT:    state_n = task_end ? DRAIN : timeout ? IDLE : WAIT;
      DRAIN:   state_n = (res_hs && res_last) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // Next values of the registered outputs; a grant landing with task_end is bypassed into word 0.
  always_comb begin
    ena_d  = op_hs ? (keep_m ? 3'b011 : 3'b111) : 3'b000;
    req_d  = state == KICK;
    done_d = (timeout && !task_end) || (res_hs && res_last);
    rv_d   = state_n == DRAIN;
    rl_d   = rv_d && idx_n == CW'(N - 1);
    rd_d   = !rv_d ? '0 : (grant_ok && rcnt == '0) ? task_res : bufm[idx_n[ADDR_W-1:0]];
    err_d  = cmd_hs ? 2'b00 : err | {timeout && !task_end,
                                     drop || (state == WAIT && task_end && rcnt_f != CW'(N))};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      op_ready  <= 1'b0;
      busy      <= 1'b0;
      wr_ena    <= '0;
      wr_addr   <= '0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_m      <= '0;
      wr_m1     <= '0;
      task_req  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_last  <= 1'b0;
      done      <= 1'b0;
      err       <= '0;
      keep_m    <= 1'b0;
      m1        <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      idx       <= '0;
      tcnt      <= '0;
      bufm      <= '{default: '0};
    end else begin
      cmd_ready <= state_n == IDLE;
      op_ready  <= state_n == LOAD;
      busy      <= state_n != IDLE;
      wr_ena    <= ena_d;
      task_req  <= req_d;
      res_valid <= rv_d;
      res_data  <= rd_d;
      res_last  <= rl_d;
      done      <= done_d;
      err       <= err_d;
      tcnt      <= state == WAIT ? tcnt + TW'(1) : '0;
      if (op_hs) begin
        wr_addr <= wcnt[ADDR_W-1:0];
        wr_x    <= op_x;
        wr_y    <= op_y;
        wr_m    <= op_m;
        wr_m1   <= m1;
        wcnt    <= wcnt + CW'(1);
      end
      if (grant_ok) begin
        bufm[rcnt[ADDR_W-1:0]] <= task_res;
        rcnt <= rcnt + CW'(1);
      end
      if (state == DRAIN) idx <= idx_n;
      if (cmd_hs) begin
        keep_m <= cmd_keep_m;
        m1     <= cmd_m1;
        wcnt   <= '0;
        rcnt   <= '0;
        idx    <= '0;
        bufm   <= '{default: '0};
      end
    end
endmodule

// File: tb/tb_mmp_iddmm_drv.sv
// tb_mmp_iddmm_drv: scenario tasks drive the driver with a host and a multiplier model;
// expected writes, results and error flags come from plain per-command bookkeeping.
module tb_mmp_iddmm_drv;
  localparam int K = 32, N = 4, AW = 2, TO = 100;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_keep_m = 0;
  logic [K-1:0] cmd_m1 = 0;
  logic op_valid = 0, op_ready;
  logic [K-1:0] op_x = 0, op_y = 0, op_m = 0;
  logic [2:0] wr_ena;
  logic [AW-1:0] wr_addr;
  logic [K-1:0] wr_x, wr_y, wr_m, wr_m1;
  logic task_req, task_end = 0, task_grant = 0;
  logic [K-1:0] task_res = 0;
  logic res_valid, res_ready = 0, res_last, busy, done;
  logic [K-1:0] res_data;
  logic [1:0] err;
  mmp_iddmm_drv #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_keep_m(cmd_keep_m), .cmd_m1(cmd_m1), .op_valid(op_valid), .op_ready(op_ready),
    .op_x(op_x), .op_y(op_y), .op_m(op_m), .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1), .task_req(task_req),
    .task_end(task_end), .task_grant(task_grant), .task_res(task_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .err(err));
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {
    int cyc;
    logic [AW-1:0] addr;
    logic [2:0] ena;
    logic [K-1:0] x, y, m, m1;
  } wr_t;
  wr_t wq[$];
  int req_q[$], done_q[$];
  logic [K-1:0] ox[N], oy[N], om[N], exp_res[N], gd[$];
  int gap[N];
  logic [1:0] exp_err;
  always @(negedge clk) begin
    wr_t w;
    cyc++;
    if (wr_ena != 3'b000) begin
      w.cyc = cyc; w.addr = wr_addr; w.ena = wr_ena;
      w.x = wr_x; w.y = wr_y; w.m = wr_m; w.m1 = wr_m1;
      wq.push_back(w);
    end
    if (task_req) req_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (rst_n && cmd_ready && busy) begin
      total++; bad++;
      $display("FAIL excl: cmd_ready=1 busy=1, want never both");
    end
  end
  task automatic step();
    @(negedge clk); #1;
  endtask
  task automatic load_ops(input bit km, input logic [K-1:0] m1v);
    int t;
    wq.delete(); req_q.delete(); done_q.delete();
    cmd_valid = 1; cmd_keep_m = km; cmd_m1 = m1v;
    t = 0;
    while (!cmd_ready && t < 50) begin step(); t++; end
    step();
    cmd_valid = 0; cmd_keep_m = 1'($urandom); cmd_m1 = $urandom;
    total++;
    if (err !== 2'b00 || busy !== 1'b1)
      begin bad++; $display("FAIL cmd_accept: err=%b busy=%b, want err=00 busy=1", err, busy); end
    for (int i = 0; i < N; i++) begin
      repeat (gap[i]) begin op_valid = 0; op_x = $urandom; step(); end
      op_valid = 1; op_x = ox[i]; op_y = oy[i]; op_m = om[i];
      t = 0;
      while (!op_ready && t < 50) begin step(); t++; end
      step();
    end
    op_valid = 0;
    t = 0;
    while (req_q.size() == 0 && t < 10) begin step(); t++; end
    total++;
    if (wq.size() != N || req_q.size() != 1) begin
      bad++; $display("FAIL write_count: writes=%0d reqs=%0d, want %0d and 1", wq.size(), req_q.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (wq[i].addr !== AW'(i) || wq[i].ena !== (km ? 3'b011 : 3'b111) || wq[i].x !== ox[i] ||
            wq[i].y !== oy[i] || wq[i].m !== om[i] || wq[i].m1 !== m1v ||
            (i > 0 && wq[i].cyc != wq[i-1].cyc + gap[i] + 1)) begin
          bad++;
          $display("FAIL write%0d: addr=%0d ena=%b x=%h y=%h m=%h m1=%h, want addr=%0d ena=%b x=%h y=%h m=%h m1=%h",
                   i, wq[i].addr, wq[i].ena, wq[i].x, wq[i].y, wq[i].m, wq[i].m1,
                   i, km ? 3'b011 : 3'b111, ox[i], oy[i], om[i], m1v);
        end
      end
      total++;
      if (req_q[0] != wq[N-1].cyc + 1)
        begin bad++; $display("FAIL req_timing: req at %0d, want %0d", req_q[0], wq[N-1].cyc + 1); end
    end
  endtask
  task automatic respond(input int ng, input bit end_same, input bit fixed);
    gd.delete();
    for (int i = 0; i < ng; i++) begin
      repeat (fixed ? 0 : $urandom % 3) step();
      task_grant = 1; task_res = fixed ? K'(32'hA0 + i) : $urandom;
      gd.push_back(task_res);
      if (i == ng - 1 && end_same) task_end = 1;
      step();
      task_grant = 0; task_end = 0;
    end
    if (!(ng > 0 && end_same)) begin task_end = 1; step(); task_end = 0; end
    for (int i = 0; i < N; i++) exp_res[i] = i < ng ? gd[i] : '0;
    exp_err = ng != N ? 2'b01 : 2'b00;
  endtask
  task automatic drain(input bit stall10);
    int t;
    for (int i = 0; i < N; i++) begin
      t = 0;
      while (!res_valid && t < 20) begin step(); t++; end
      if (stall10 && i == 0) begin
        res_ready = 0;
        for (int s = 0; s < 10; s++) begin
          total++;
          if (res_valid !== 1'b1 || res_data !== exp_res[0])
            begin bad++; $display("FAIL stall%0d: valid=%b data=%h, want 1 %h", s, res_valid, res_data, exp_res[0]); end
          step();
        end
      end
      repeat ($urandom % 3) begin res_ready = 0; step(); end
      total++;
      if (res_valid !== 1'b1 || res_data !== exp_res[i] || res_last !== (i == N - 1))
        begin bad++; $display("FAIL word%0d: valid=%b data=%h last=%b, want 1 %h %b", i, res_valid, res_data, res_last, exp_res[i], i == N - 1); end
      res_ready = 1; step(); res_ready = 0;
    end
    total++;
    if (done !== 1'b1 || err !== exp_err || busy !== 1'b0 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL drain_end: done=%b err=%b busy=%b cmd_ready=%b, want 1 %b 0 1", done, err, busy, cmd_ready, exp_err); end
    step();
    total++;
    if (done !== 1'b0 || req_q.size() != 1 || done_q.size() != 1)
      begin bad++; $display("FAIL done_pulse: done=%b reqs=%0d dones=%0d, want 0 1 1", done, req_q.size(), done_q.size()); end
  endtask
  task automatic test_reset();
    #2;
    total++;
    if ({cmd_ready, op_ready, wr_ena, task_req, res_valid, res_last, busy, done, err} !== '0)
      begin bad++; $display("FAIL reset_outputs: cmd_ready=%b busy=%b err=%b, want all 0", cmd_ready, busy, err); end
    repeat (3) step();
    rst_n = 1;
    step(); step();
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL reset_idle: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy); end
  endtask
  task automatic test_basic();
    for (int i = 0; i < N; i++) begin
      ox[i] = K'(i + 1); oy[i] = K'(i + 5); om[i] = K'(i + 9); gap[i] = 0;
    end
    load_ops(0, 32'h77);
    respond(N, 0, 1);
    drain(0);
  endtask
  task automatic test_keep_m();
    for (int i = 0; i < N; i++) begin
      ox[i] = $urandom; oy[i] = $urandom; om[i] = $urandom; gap[i] = i % 2;
    end
    load_ops(1, $urandom);
    respond(N, 1, 0);
    drain(0);
  endtask
  task automatic test_mismatch();
    load_ops(0, $urandom);
    respond(3, 0, 0);
    drain(0);
    load_ops(1, $urandom);
    respond(5, 1, 0);
    drain(0);
  endtask
  task automatic test_stall_stray();
    load_ops(0, $urandom);
    respond(N, 0, 0);
    drain(1);
    task_grant = 1; task_end = 1; task_res = $urandom;
    for (int s = 0; s < 3; s++) begin
      step();
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || err !== 2'b00 || res_valid !== 1'b0 || done !== 1'b0)
        begin bad++; $display("FAIL stray%0d: busy=%b cmd_ready=%b err=%b valid=%b done=%b, want 0 1 00 0 0", s, busy, cmd_ready, err, res_valid, done); end
    end
    task_grant = 0; task_end = 0;
  endtask
  task automatic test_timeout();
    int t;
    load_ops(0, $urandom);
    t = 0;
    while (done_q.size() == 0 && t < TO + 20) begin step(); t++; end
    total++;
    if (done_q.size() != 1 || done_q[0] - req_q[0] != TO || done !== 1'b1 || err !== 2'b10 ||
        cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0)
      begin bad++; $display("FAIL timeout: dones=%0d delay=%0d err=%b cmd_ready=%b busy=%b, want 1 %0d 10 1 0",
                            done_q.size(), done_q.size() ? done_q[0] - req_q[0] : -1, err, cmd_ready, busy, TO); end
    step();
    total++;
    if (done !== 1'b0 || req_q.size() != 1 || err !== 2'b10)
      begin bad++; $display("FAIL timeout_after: done=%b reqs=%0d err=%b, want 0 1 10", done, req_q.size(), err); end
  endtask
  task automatic test_reset_mid();
    load_ops(0, $urandom);
    task_grant = 1; task_res = $urandom; step(); task_res = $urandom; step(); task_grant = 0;
    #2 rst_n = 0;
    #1;
    wq.delete(); req_q.delete();
    total++;
    if ({cmd_ready, op_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
         res_valid, res_data, res_last, busy, done, err} !== '0)
      begin bad++; $display("FAIL async_reset: busy=%b task_req=%b err=%b, want all outputs 0", busy, task_req, err); end
    step(); step();
    rst_n = 1;
    step(); step();
    total++;
    if (wq.size() != 0 || req_q.size() != 0 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL post_reset: writes=%0d reqs=%0d cmd_ready=%b, want 0 0 1", wq.size(), req_q.size(), cmd_ready); end
    for (int i = 0; i < N; i++) begin
      ox[i] = $urandom; oy[i] = $urandom; om[i] = $urandom; gap[i] = 0;
    end
    load_ops(0, $urandom);
    respond(N, 0, 0);
    drain(0);
  endtask
  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        ox[i] = $urandom; oy[i] = $urandom; om[i] = $urandom; gap[i] = $urandom % 3;
      end
      load_ops(1'($urandom), $urandom);
      respond(N - 1 + $urandom % 3, 1'($urandom), 0);
      drain(0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_basic();
    test_keep_m();
    test_mismatch();
    test_stall_stray();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
